// File: rtl/chroma_pkg.sv
// Shared chroma-adaptation types, Q16.16 constants and slice helpers.
// Used by the adaptation scheduler and the sensor filter blocks.
package chroma_pkg;

    localparam int XYZ_W = 96;
    localparam int MAT_W = 288;
    localparam int EL_W  = 32;

    localparam logic [EL_W-1:0] FP_ONE = 32'h0001_0000;

    // Element (r,c) sits at [(3r+c)*32 +: 32]; the diagonal is 0, 4, 8.
    localparam logic [MAT_W-1:0] IDENTITY_MATRIX_288 =
        {FP_ONE, 96'h0, FP_ONE, 96'h0, FP_ONE};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } sched_state_e;

    function automatic logic [EL_W-1:0] xyz_el(
        input logic [XYZ_W-1:0] v,
        input int               i
    );
        return v[i*EL_W +: EL_W];
    endfunction

    function automatic logic [EL_W-1:0] mat_el(
        input logic [MAT_W-1:0] m,
        input int               r,
        input int               c
    );
        return m[(3*r+c)*EL_W +: EL_W];
    endfunction

    // Unsigned magnitude of a-b, one bit wider so nothing wraps.
    function automatic logic [EL_W:0] abs_diff(
        input logic [EL_W-1:0] a,
        input logic [EL_W-1:0] b
    );
        if (a >= b) return {1'b0, a} - {1'b0, b};
        else        return {1'b0, b} - {1'b0, a};
    endfunction

endpackage

// File: rtl/xyz_delta_detect.sv
// Flags when any XYZ component of a and b differs by more than THRESH.
// Ports: a, b (Q16.16 XYZ triplets), changed (combinational result).
module xyz_delta_detect
    import chroma_pkg::*;
#(
    parameter logic [31:0] THRESH = 32'h0000_0400
) (
    input  logic [XYZ_W-1:0] a,
    input  logic [XYZ_W-1:0] b,
    output logic             changed
);

    logic [2:0] hit;

    always_comb begin
        hit = '0;
        for (int i = 0; i < 3; i++) begin
            hit[i] = abs_diff(xyz_el(a, i), xyz_el(b, i)) > {1'b0, THRESH};
        end
    end

    assign changed = |hit;

endmodule

// File: rtl/adapt_matrix_scheduler.sv
// Filters ambient XYZ samples, launches the Bradford engine, supervises it
// with a timeout and double-buffers its 3x3 result onto frame boundaries.
// Ports: clk, rst_n; adapt_en, sensor_xyz/valid, frame_start in;
// eng_xyz/eng_start to the engine, eng_matrix/valid back from it;
// active_matrix, busy, timeout_err, update_count out.
module adapt_matrix_scheduler
    import chroma_pkg::*;
#(
    parameter logic [31:0] DELTA_THRESH = 32'h0000_0400,
    parameter int          MIN_INTERVAL = 1024,
    parameter int          TIMEOUT      = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adapt_en,
    input  logic [XYZ_W-1:0] sensor_xyz,
    input  logic             sensor_valid,
    input  logic             frame_start,
    output logic [XYZ_W-1:0] eng_xyz,
    output logic             eng_start,
    input  logic [MAT_W-1:0] eng_matrix,
    input  logic             eng_matrix_valid,
    output logic [MAT_W-1:0] active_matrix,
    output logic             busy,
    output logic             timeout_err,
    output logic [15:0]      update_count
);

    localparam int IW = (MIN_INTERVAL > 1) ? $clog2(MIN_INTERVAL) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IW-1:0] IVL_LOAD = IW'(MIN_INTERVAL - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    sched_state_e     state, state_nx;
    logic [XYZ_W-1:0] pend, last;
    logic             pend_valid, have_last;
    logic [MAT_W-1:0] shadow;
    logic             shadow_full;
    logic [IW-1:0]    ivl;
    logic [TW-1:0]    tmo;

    logic changed, sample_ok, qual;
    logic do_launch, drop, eng_done, abort;
    logic swap_new, swap_id;

    xyz_delta_detect #(
        .THRESH (DELTA_THRESH)
    ) u_delta (
        .a       (pend),
        .b       (last),
        .changed (changed)
    );

    // A sample with Y == 0 cannot be normalised by the engine.
    assign sample_ok = sensor_valid && (xyz_el(sensor_xyz, 1) != '0);
    assign qual      = pend_valid && adapt_en && (ivl == '0);

    // Swap reads the pre-edge shadow_full, so a coincident completion
    // lands in the shadow and waits for the next frame.
    assign swap_new = frame_start && shadow_full && adapt_en;
    assign swap_id  = frame_start && !adapt_en &&
                      (active_matrix != IDENTITY_MATRIX_288);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        eng_start = 1'b0;
        busy      = 1'b0;
        do_launch = 1'b0;
        drop      = 1'b0;
        eng_done  = 1'b0;
        abort     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (qual) begin
                    if (!have_last || changed) begin
                        do_launch = 1'b1;
                        state_nx  = ST_LAUNCH;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            ST_LAUNCH: begin
                eng_start = 1'b1;
                busy      = 1'b1;
                state_nx  = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (eng_matrix_valid) begin
                    eng_done = 1'b1;
                    state_nx = ST_IDLE;
                end else if (tmo == TMO_LAST) begin
                    abort    = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend          <= '0;
            pend_valid    <= 1'b0;
            last          <= '0;
            have_last     <= 1'b0;
            eng_xyz       <= '0;
            ivl           <= '0;
            tmo           <= '0;
            shadow        <= '0;
            shadow_full   <= 1'b0;
            timeout_err   <= 1'b0;
            active_matrix <= IDENTITY_MATRIX_288;
            update_count  <= '0;
        end else begin
            if (sample_ok) begin
                pend       <= sensor_xyz;
                pend_valid <= 1'b1;
            end else if (do_launch || drop) begin
                pend_valid <= 1'b0;
            end
            if (!adapt_en) pend_valid <= 1'b0;

            if (do_launch) begin
                eng_xyz   <= pend;
                last      <= pend;
                have_last <= 1'b1;
            end

            if (do_launch)      ivl <= IVL_LOAD;
            else if (ivl != '0) ivl <= ivl - 1'b1;

            if (state == ST_LAUNCH)    tmo <= '0;
            else if (state == ST_WAIT) tmo <= tmo + 1'b1;

            if (eng_done) shadow <= eng_matrix;
            // Results finishing while disabled are dropped here.
            if (eng_done && adapt_en)      shadow_full <= 1'b1;
            else if (swap_new || !adapt_en) shadow_full <= 1'b0;

            if (eng_done)   timeout_err <= 1'b0;
            else if (abort) timeout_err <= 1'b1;

            if (swap_new) begin
                active_matrix <= shadow;
                update_count  <= update_count + 1'b1;
            end else if (swap_id) begin
                active_matrix <= IDENTITY_MATRIX_288;
                update_count  <= update_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/adapt_matrix_scheduler.md
Name: adapt_matrix_scheduler

Overview:
- Sequences the Bradford chromatic-adaptation engine, which sits between the ambient sensor path and the pixel colour-correction stage.
- Filters and rate-limits ambient XYZ samples, launches the engine, holds its operand stable and supervises completion with a timeout.
- Double-buffers the resulting 3x3 compensation matrix; the matrix seen by the pixel datapath changes only at a frame boundary.

Parameters:
- DELTA_THRESH, 32'h00000400, minimum per-component |change| (Q16.16) that triggers recomputation.
- MIN_INTERVAL, 1024, minimum clk cycles between two engine launches.
- TIMEOUT, 64, max cycles from launch to eng_matrix_valid before abort.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- adapt_en  in  1  enables adaptation; 0 = bypass to identity
- sensor_xyz  in  96  ambient XYZ, Q16.16 unsigned; X[31:0] Y[63:32] Z[95:64]
- sensor_valid  in  1  one-cycle qualifier for sensor_xyz
- frame_start  in  1  one-cycle pulse at the start of each video frame
- eng_xyz  out  96  operand to engine ambient_xyz
- eng_start  out  1  one-cycle pulse to engine xyz_valid
- eng_matrix  in  288  engine comp_matrix; element (r,c) at [(3r+c)*32 +: 32]
- eng_matrix_valid  in  1  engine completion pulse
- active_matrix  out  288  matrix applied to pixels, same packing
- busy  out  1  engine launched and not yet complete or aborted
- timeout_err  out  1  sticky abort flag
- update_count  out  16  number of matrix swaps into active_matrix

Behaviour:
- Reset: one clock; reset is asynchronous, active-low (rst_n). Reset values:
  - active_matrix = identity (diagonal 32'h00010000, others 0)
  - eng_xyz = 0; eng_start, busy, timeout_err = 0; update_count = 0
  - FSM = IDLE; shadow_full = 0; have_last = 0; pend_valid = 0; interval counter = 0
- Sample intake, every cycle:
  - sensor_valid with Y == 0: sample dropped.
  - Otherwise the sample is written into the pend register and pend_valid is set. The latest sample wins, including while busy.
- Launch qualification: pend_valid && adapt_en && interval counter == 0, and either have_last == 0 or at least one component has |pend - last_launched| > DELTA_THRESH.
  - Compare is 33-bit unsigned difference, no wrap.
  - A qualifying-but-unchanged sample clears pend_valid without launching.
- FSM IDLE: on launch qualification:
  - eng_xyz <= pend; last_launched <= pend; have_last <= 1; pend_valid <= 0
  - interval counter <= MIN_INTERVAL-1; go to LAUNCH.
- FSM LAUNCH (1 cycle): eng_start = 1, busy = 1, timeout counter cleared; go to WAIT_ENG.
- FSM WAIT_ENG:
  - eng_xyz held constant; the engine samples it two cycles after start.
  - On eng_matrix_valid: shadow <= eng_matrix, shadow_full <= 1, timeout_err <= 0, busy <= 0, go to IDLE.
  - When the timeout counter reaches TIMEOUT-1 without completion: timeout_err <= 1, busy <= 0, go to IDLE, shadow untouched.
- Nominal engine latency: eng_matrix_valid arrives 6 cycles after eng_start.
- eng_matrix_valid outside WAIT_ENG (e.g. late after timeout) is ignored.
- The interval counter decrements every cycle while nonzero, independent of FSM state.
- Swap, on frame_start:
  - If shadow_full && adapt_en: active_matrix <= shadow, shadow_full <= 0, update_count++ (wraps at 16'hFFFF -> 0).
  - If !adapt_en and active_matrix differs from identity: active_matrix <= identity, update_count++.
- Simultaneous frame_start and eng_matrix_valid:
  - The swap uses the old shadow state: if shadow_full was 0, nothing swaps.
  - The new result is written to shadow and is applied at the next frame_start.
  - A newer result overwrites an unswapped shadow.
- adapt_en falling: shadow_full <= 0 and pend_valid <= 0 immediately. An in-flight computation completes, but its result is discarded.
- No arithmetic is performed on matrices; values pass through unmodified.

Decomposition:
- Shared package chroma_pkg:
  - Q16.16 constants: FP_ONE, IDENTITY_MATRIX_288
  - widths: XYZ_W = 96, MAT_W = 288
  - element-slice helpers and FSM state encodings
- One natural sub-module: xyz_delta_detect (combinational 3-component |a-b| > threshold compare), reused by future sensor filters.

Test Plan:
- Reset with no stimulus: active_matrix = identity, update_count = 0. First sample (X=F852,Y=10000,Z=10721): eng_start pulses 1 cycle later, eng_xyz holds. Matrix pulse 6 cycles later, then next frame_start: active_matrix = that matrix, update_count = 1.
- Second sample differing by 0x200 in X only, after interval expiry -> no eng_start. Differing by 0x500 -> launch.
- Two samples 10 cycles apart (MIN_INTERVAL = 1024) -> one launch at once. Second launch exactly 1024 cycles after the first, with the latest sample.
- Engine never responds -> timeout_err = 1 and busy = 0 at launch+65. A late eng_matrix_valid is ignored and active_matrix is unchanged. The next successful run clears timeout_err.
- frame_start coincident with eng_matrix_valid -> active_matrix unchanged that frame, updated at the following frame_start.
- Drop adapt_en with a non-identity active_matrix -> identity at next frame_start, shadow discarded. Sample with Y = 0 -> no launch.
